multi_cycle_control: RTL and testbench
======================================

MULTI_CYCLE_CONTROL -- requirements
Module: multi_cycle_control

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock, all state updates on rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-003 SHALL have port opcode, input, 6 bits: instruction[31:26] from the external instruction register, stable from DECODE onward.
REQ-004 SHALL have port mem_ready, input, 1 bit: memory access completes in the current cycle.
REQ-005 SHALL have outputs PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite, RegWrite, RegDst, ALUSrcA, each 1 bit: datapath control strobes and mux selects.
REQ-006 SHALL have outputs PCSource[1:0], ALUSrcB[1:0] and ALUOp[1:0], each 2 bits; ALUOp encoding: 00 add, 01 subtract, 10 funct-decoded.
REQ-007 SHALL have output state[3:0], 4 bits: current FSM state code.
REQ-008 SHALL have output illegal_op, 1 bit: unrecognised opcode flag.

Function
REQ-009 SHALL implement a Moore FSM with state codes FETCH=0, DECODE=1, MEM_ADDR=2, MEM_RD=3, MEM_WB=4, MEM_WR=5, EXEC=6, R_WB=7, BRANCH=8, JUMP=9, ADDI_EX=10, ADDI_WB=11; codes 12-15 are unused.
REQ-010 SHALL decode all outputs combinationally from state (plus mem_ready and opcode where stated); every output not listed for a state is 0.
REQ-011 FETCH SHALL drive MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00, with PCWrite=IRWrite=mem_ready.
REQ-012 FETCH SHALL hold while mem_ready=0 and go to DECODE on mem_ready=1.
REQ-013 DECODE SHALL drive ALUSrcA=0, ALUSrcB=11, ALUOp=00.
REQ-014 DECODE SHALL branch on opcode: 100011/101011 to MEM_ADDR; 000000 to EXEC; 000100 to BRANCH; 000010 to JUMP; 001000 to ADDI_EX; any other value to FETCH with illegal_op=1 during that DECODE cycle only.
REQ-015 MEM_ADDR SHALL drive ALUSrcA=1, ALUSrcB=10, ALUOp=00, then go to MEM_RD if opcode=100011, else MEM_WR.
REQ-016 MEM_RD SHALL drive MemRead=1, IorD=1, hold while mem_ready=0, and go to MEM_WB on mem_ready=1.
REQ-017 MEM_WB SHALL drive RegWrite=1, MemtoReg=1, RegDst=0, then go to FETCH.
REQ-018 MEM_WR SHALL drive MemWrite=1, IorD=1, hold while mem_ready=0, and go to FETCH on mem_ready=1.
REQ-019 EXEC SHALL drive ALUSrcA=1, ALUSrcB=00, ALUOp=10, then go to R_WB; R_WB SHALL drive RegWrite=1, RegDst=1, MemtoReg=0, then go to FETCH.
REQ-020 BRANCH SHALL drive ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01, then go to FETCH.
REQ-021 JUMP SHALL drive PCWrite=1, PCSource=10, then go to FETCH.
REQ-022 ADDI_EX SHALL drive ALUSrcA=1, ALUSrcB=10, ALUOp=00, then go to ADDI_WB; ADDI_WB SHALL drive RegWrite=1, RegDst=0, MemtoReg=0, then go to FETCH.
REQ-023 Unused codes 12-15 SHALL drive all outputs 0 and go to FETCH on the next edge.
REQ-024 mem_ready SHALL be ignored in every state other than FETCH, MEM_RD and MEM_WR.
REQ-025 Cycle counts with mem_ready tied to 1 SHALL be: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, illegal 2.

Reset
REQ-026 rst=1 at a rising edge SHALL force state to FETCH, overriding any transition, including mid-instruction and mid-stall.
REQ-027 While rst=1, PCWrite, PCWriteCond, IRWrite, MemWrite, MemRead and RegWrite SHALL be forced to 0 combinationally.
REQ-028 After rst deasserts, the first cycle SHALL be FETCH with FETCH outputs per REQ-011.

Verification
REQ-029 Reset then lw (100011), mem_ready=1 -> state sequence 0,1,2,3,4,0; RegWrite=1, MemtoReg=1 only in state 4.
REQ-030 sw (101011) with mem_ready=0 for 3 cycles in MEM_WR -> state held at 5 for 4 cycles; MemWrite=1 throughout; FETCH follows.
REQ-031 FETCH with mem_ready=0 for 2 cycles, then 1 -> PCWrite=IRWrite=0 for 2 cycles, 1 on the third; DECODE follows.
REQ-032 R-type, beq, j, addi in sequence -> ALUOp 10 in EXEC, 01 in BRANCH; PCSource 10 in JUMP; RegDst 1 in R_WB, 0 in ADDI_WB.
REQ-033 Opcode 111111 -> illegal_op=1 for exactly the DECODE cycle; next state 0; no write strobe asserted.
REQ-034 rst=1 asserted while in MEM_RD -> state=0 next cycle; MemRead=0 during the rst cycle.

Source files
------------

// File: rtl/multi_cycle_control.sv
// rtl/multi_cycle_control.sv - Moore control FSM for a multi-cycle MIPS-style datapath
//
// Purpose: sequences fetch, decode, memory, execute and write-back steps for
// lw, sw, R-type, beq, j and addi, emitting datapath strobes and mux selects.
//
// Ports:
//   clk         in   clock, all state updates on the rising edge
//   rst         in   synchronous active-high reset, returns to FETCH
//   opcode[5:0] in   instruction[31:26], stable from DECODE onward
//   mem_ready   in   memory access completes this cycle
//   PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
//   RegWrite, RegDst, ALUSrcA            out  1-bit strobes / selects
//   PCSource[1:0], ALUSrcB[1:0], ALUOp[1:0]  out  2-bit selects (ALUOp 00 add, 01 sub, 10 funct)
//   state[3:0]  out  current state code
//   illegal_op  out  high during a DECODE cycle holding an unrecognised opcode

module multi_cycle_control (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       MemtoReg,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic       RegDst,
    output logic       ALUSrcA,
    output logic [1:0] PCSource,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [3:0] state,
    output logic       illegal_op
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEM_ADDR = 4'd2,
        MEM_RD   = 4'd3,
        MEM_WB   = 4'd4,
        MEM_WR   = 4'd5,
        EXEC     = 4'd6,
        R_WB     = 4'd7,
        BRANCH   = 4'd8,
        JUMP     = 4'd9,
        ADDI_EX  = 4'd10,
        ADDI_WB  = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    state_t state_q;
    state_t state_d;

    assign state = state_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = FETCH;
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        MemtoReg    = 1'b0;
        IRWrite     = 1'b0;
        RegWrite    = 1'b0;
        RegDst      = 1'b0;
        ALUSrcA     = 1'b0;
        PCSource    = 2'b00;
        ALUSrcB     = 2'b00;
        ALUOp       = 2'b00;
        illegal_op  = 1'b0;

        case (state_q)
            FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                // PC increment and IR load only commit once the fetch completes
                PCWrite = mem_ready;
                IRWrite = mem_ready;
                state_d = mem_ready ? DECODE : FETCH;
            end
            DECODE: begin
                ALUSrcB = 2'b11;
                case (opcode)
                    OP_LW, OP_SW: state_d = MEM_ADDR;
                    OP_RTYPE:     state_d = EXEC;
                    OP_BEQ:       state_d = BRANCH;
                    OP_J:         state_d = JUMP;
                    OP_ADDI:      state_d = ADDI_EX;
                    default: begin
                        illegal_op = 1'b1;
                        state_d    = FETCH;
                    end
                endcase
            end
            MEM_ADDR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                state_d = (opcode == OP_LW) ? MEM_RD : MEM_WR;
            end
            MEM_RD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
                state_d = mem_ready ? MEM_WB : MEM_RD;
            end
            MEM_WB: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
                state_d  = FETCH;
            end
            MEM_WR: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
                state_d  = mem_ready ? FETCH : MEM_WR;
            end
            EXEC: begin
                ALUSrcA = 1'b1;
                ALUOp   = 2'b10;
                state_d = R_WB;
            end
            R_WB: begin
                RegWrite = 1'b1;
                RegDst   = 1'b1;
                state_d  = FETCH;
            end
            BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUOp       = 2'b01;
                PCWriteCond = 1'b1;
                PCSource    = 2'b01;
                state_d     = FETCH;
            end
            JUMP: begin
                PCWrite  = 1'b1;
                PCSource = 2'b10;
                state_d  = FETCH;
            end
            ADDI_EX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                state_d = ADDI_WB;
            end
            ADDI_WB: begin
                RegWrite = 1'b1;
                state_d  = FETCH;
            end
            // codes 12-15: all outputs stay 0, recover to FETCH
            default: state_d = FETCH;
        endcase

        // Architectural write/read strobes are suppressed while reset is held so
        // a reset landing mid-instruction cannot commit a partial access.
        if (rst) begin
            PCWrite     = 1'b0;
            PCWriteCond = 1'b0;
            IRWrite     = 1'b0;
            MemWrite    = 1'b0;
            MemRead     = 1'b0;
            RegWrite    = 1'b0;
        end
    end

endmodule

// File: tb/tb_multi_cycle_control.sv
// tb/tb_multi_cycle_control.sv - scoreboard bench for multi_cycle_control

module tb_multi_cycle_control;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] opcode = 6'd0;
    logic       mem_ready = 1'b0;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg;
    logic       IRWrite, RegWrite, RegDst, ALUSrcA;
    logic [1:0] PCSource, ALUSrcB, ALUOp;
    logic [3:0] state;
    logic       illegal_op;

    multi_cycle_control dut (
        .clk        (clk),
        .rst        (rst),
        .opcode     (opcode),
        .mem_ready  (mem_ready),
        .PCWrite    (PCWrite),
        .PCWriteCond(PCWriteCond),
        .IorD       (IorD),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .MemtoReg   (MemtoReg),
        .IRWrite    (IRWrite),
        .RegWrite   (RegWrite),
        .RegDst     (RegDst),
        .ALUSrcA    (ALUSrcA),
        .PCSource   (PCSource),
        .ALUSrcB    (ALUSrcB),
        .ALUOp      (ALUOp),
        .state      (state),
        .illegal_op (illegal_op)
    );

    always #5 clk = ~clk;

    // {state, PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
    //  RegWrite, RegDst, ALUSrcA, PCSource, ALUSrcB, ALUOp, illegal_op}
    logic [20:0] dut_word;
    assign dut_word = {state, PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg,
                       IRWrite, RegWrite, RegDst, ALUSrcA, PCSource, ALUSrcB, ALUOp,
                       illegal_op};

    logic [20:0] exp_q[$];
    int          n_compared = 0;
    int          n_failed   = 0;
    int          cyc        = 0;

    // instruction-level reference model: each instruction is a list of steps
    int          recipe[$];
    int          idx;
    logic [5:0]  cur_op;
    logic [5:0]  directed_ops[$];

    function automatic bit is_legal(logic [5:0] op);
        return op inside {6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b000010, 6'b001000};
    endfunction

    function automatic logic [20:0] exp_word(int st, bit mr, bit r, logic [5:0] op);
        bit pcw = 0, pcwc = 0, iord = 0, mrd = 0, mwr = 0, m2r = 0;
        bit irw = 0, rw = 0, rdst = 0, asa = 0, ill = 0;
        logic [1:0] pcs = 0, asb = 0, aop = 0;
        logic [3:0] s;
        case (st)
            0:  begin mrd = 1; asb = 2'b01; pcw = mr; irw = mr; end
            1:  begin asb = 2'b11; ill = !is_legal(op); end
            2:  begin asa = 1; asb = 2'b10; end
            3:  begin mrd = 1; iord = 1; end
            4:  begin rw = 1; m2r = 1; end
            5:  begin mwr = 1; iord = 1; end
            6:  begin asa = 1; aop = 2'b10; end
            7:  begin rw = 1; rdst = 1; end
            8:  begin asa = 1; aop = 2'b01; pcwc = 1; pcs = 2'b01; end
            9:  begin pcw = 1; pcs = 2'b10; end
            10: begin asa = 1; asb = 2'b10; end
            11: begin rw = 1; end
            default: ;
        endcase
        if (r) begin
            pcw = 0; pcwc = 0; irw = 0; mwr = 0; mrd = 0; rw = 0;
        end
        s = st[3:0];
        return {s, pcw, pcwc, iord, mrd, mwr, m2r, irw, rw, rdst, asa, pcs, asb, aop, ill};
    endfunction

    task automatic start_instr();
        int pick;
        if (directed_ops.size() > 0) begin
            cur_op = directed_ops.pop_front();
        end else begin
            pick = $urandom_range(0, 6);
            case (pick)
                0: cur_op = 6'b100011;
                1: cur_op = 6'b101011;
                2: cur_op = 6'b000000;
                3: cur_op = 6'b000100;
                4: cur_op = 6'b000010;
                5: cur_op = 6'b001000;
                default: begin
                    cur_op = 6'($urandom_range(0, 63));
                    while (is_legal(cur_op)) cur_op = 6'($urandom_range(0, 63));
                end
            endcase
        end
        case (cur_op)
            6'b100011: recipe = '{0, 1, 2, 3, 4};
            6'b101011: recipe = '{0, 1, 2, 5};
            6'b000000: recipe = '{0, 1, 6, 7};
            6'b000100: recipe = '{0, 1, 8};
            6'b000010: recipe = '{0, 1, 9};
            6'b001000: recipe = '{0, 1, 10, 11};
            default:   recipe = '{0, 1};
        endcase
        idx = 0;
    endtask

    // One clock cycle: apply inputs after the edge, record what the DUT must show
    // this cycle, then advance the model.
    task automatic drive_cycle(bit mr, bit r);
        int st;
        @(posedge clk);
        #1;
        opcode    = cur_op;
        mem_ready = mr;
        rst       = r;
        st = recipe[idx];
        exp_q.push_back(exp_word(st, mr, r, cur_op));
        if (r) begin
            idx = 0;
        end else if ((st == 0 || st == 3 || st == 5) && !mr) begin
            idx = idx;
        end else begin
            idx++;
            if (idx >= recipe.size()) start_instr();
        end
    endtask

    // monitor: outputs are settled mid-cycle, compare on the falling edge
    initial begin
        logic [20:0] e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_compared++;
                if (dut_word !== e) begin
                    n_failed++;
                    $display("FAIL ctrl_word cyc %0d: got state=%0d word=%h, expected state=%0d word=%h",
                             cyc, dut_word[20:17], dut_word, e[20:17], e);
                end
            end
            cyc++;
        end
    end

    initial begin
        int wait_cnt;
        directed_ops = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b000010,
                         6'b001000, 6'b111111, 6'b100011};
        start_instr();

        // reset held for two cycles
        drive_cycle(1'b0, 1'b1);
        drive_cycle(1'b1, 1'b1);

        // lw; sw with 2 FETCH stalls and 3 MEM_WR stalls; R, beq, j, addi, illegal;
        // lw reset while in MEM_RD
        for (int t = 0; t < 34; t++) begin
            bit mr;
            mr = !(t == 5 || t == 6 || t == 10 || t == 11 || t == 12);
            drive_cycle(mr, t == 33);
        end

        for (int t = 0; t < 3000; t++) begin
            drive_cycle($urandom_range(0, 3) != 0, $urandom_range(0, 49) == 0);
        end

        wait_cnt = 0;
        while (exp_q.size() > 0 && wait_cnt < 10) begin
            @(posedge clk);
            wait_cnt++;
        end
        if (exp_q.size() > 0) begin
            n_compared++;
            n_failed++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
        $finish;
    end

endmodule
